// File: rtl/bp_input_assembler_if.sv
// Handshake bundle between the input DMA, the input assembler and the butterfly engines.
// Carries per-channel AXI beats upstream and per-channel assembled slices downstream.
// The engines share a single ready; each channel has its own valid on both sides.
interface bp_input_assembler_if #(
  parameter int DATA_WIDTH_AXI = 256,
  parameter int INPUT_AXI_CHNL = 8,
  parameter int data_width     = 16,
  parameter int be_parallelism = 128
);
  logic [DATA_WIDTH_AXI*INPUT_AXI_CHNL-1:0] s_axi_dat;
  logic [INPUT_AXI_CHNL-1:0]                s_axi_vld;
  logic [INPUT_AXI_CHNL-1:0]                s_axi_rdy;
  logic [2*data_width*be_parallelism-1:0]   dn_dat;
  logic [INPUT_AXI_CHNL-1:0]                dn_vld;
  logic                                     dn_rdy;

  modport master (
    output s_axi_dat, s_axi_vld, dn_rdy,
    input  s_axi_rdy, dn_dat, dn_vld
  );

  modport slave (
    input  s_axi_dat, s_axi_vld, dn_rdy,
    output s_axi_rdy, dn_dat, dn_vld
  );
endinterface

// File: rtl/bp_input_assembler.sv
// Assembles per-channel AXI beats into the wide real+imag vector feeding the butterfly engines.
// Latency: last beat of a slice accepted at cycle N -> dn_vld at N+1; one slice per BEATS cycles.
// Backpressure: one pending slice per channel is buffered, then s_axi_rdy drops until dn_rdy frees it.
module bp_input_assembler #(
  parameter int DATA_WIDTH_AXI = 256,
  parameter int INPUT_AXI_CHNL = 8,
  parameter int data_width     = 16,
  parameter int be_parallelism = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                length,
  output logic                       busy,
  output logic                       done,
  bp_input_assembler_if.slave        link
);
  localparam int CHNL_W = 2*data_width*be_parallelism/INPUT_AXI_CHNL;
  localparam int BEATS  = CHNL_W/DATA_WIDTH_AXI;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [15:0]               len_q;
  logic                      zero_q;
  logic [31:0]               total_beats;
  logic                      frame_go;
  logic [INPUT_AXI_CHNL-1:0] chnl_fin;

  assign total_beats = {16'd0, len_q} * 32'(BEATS);
  assign frame_go    = (state == IDLE) && start && (length != 16'd0);

  // Frame state register, latched length and the zero-length done marker
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      zero_q <= (state == IDLE) && start && (length == 16'd0);
      if (frame_go) len_q <= length;
    end
  end

  // Next-state and status outputs; a frame ends once every channel has drained
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = zero_q;
    unique case (state)
      IDLE: if (frame_go) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (&chnl_fin) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar c = 0; c < INPUT_AXI_CHNL; c++) begin : g_chnl
    logic [IDX_W-1:0]          beat_idx;
    logic [31:0]               beats_acc;
    logic [15:0]               vec_cnt;
    logic [CHNL_W-1:0]         asm_q;
    logic [CHNL_W-1:0]         asm_merged;
    logic [CHNL_W-1:0]         out_q;
    logic                      asm_full;
    logic                      out_vld;
    logic [DATA_WIDTH_AXI-1:0] beat;
    logic                      rdy;
    logic                      accept;
    logic                      last;
    logic                      out_free;
    logic                      hs;

    assign beat     = link.s_axi_dat[c*DATA_WIDTH_AXI +: DATA_WIDTH_AXI];
    // Ready depends only on registered state, never on dn_rdy
    assign rdy      = (state == RUN) && !asm_full && (beats_acc < total_beats);
    assign accept   = link.s_axi_vld[c] && rdy;
    assign last     = accept && (beat_idx == LAST_IDX);
    assign out_free = !out_vld || link.dn_rdy;
    assign hs       = out_vld && link.dn_rdy;

    assign link.s_axi_rdy[c]                = rdy;
    assign link.dn_vld[c]                   = out_vld;
    assign link.dn_dat[c*CHNL_W +: CHNL_W]  = out_q;
    assign chnl_fin[c]                      = (vec_cnt == len_q) && !out_vld;

    // Slice being assembled with the current beat dropped into its position (first beat in LSBs)
    always_comb begin
      asm_merged = asm_q;
      asm_merged[int'(beat_idx)*DATA_WIDTH_AXI +: DATA_WIDTH_AXI] = beat;
    end

    // Beat collection, hand-off of complete slices into the output register, and vector counting
    always_ff @(posedge clk) begin
      if (rst) begin
        beat_idx  <= '0;
        beats_acc <= '0;
        vec_cnt   <= '0;
        asm_q     <= '0;
        out_q     <= '0;
        asm_full  <= 1'b0;
        out_vld   <= 1'b0;
      end else if (frame_go) begin
        beat_idx  <= '0;
        beats_acc <= '0;
        vec_cnt   <= '0;
        asm_full  <= 1'b0;
        out_vld   <= 1'b0;
      end else begin
        if (accept) begin
          asm_q     <= asm_merged;
          beat_idx  <= last ? '0 : beat_idx + IDX_W'(1);
          beats_acc <= beats_acc + 32'd1;
        end
        if (hs) vec_cnt <= vec_cnt + 16'd1;
        // A freshly completed slice and a pending one are exclusive: ready is low while asm_full
        if (last && out_free) begin
          out_q   <= asm_merged;
          out_vld <= 1'b1;
        end else if (asm_full && out_free) begin
          out_q    <= asm_q;
          out_vld  <= 1'b1;
          asm_full <= 1'b0;
        end else if (hs) begin
          out_vld <= 1'b0;
        end
        if (last && !out_free) asm_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bp_input_assembler.sv
// Directed bench for bp_input_assembler: hand-computed cycle tables per scenario plus
// an in-order slice check on every valid output cycle.
// Inputs driven and outputs sampled on the falling edge.
module tb_bp_input_assembler;
  localparam int NC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] length;
  logic        busy;
  logic        done;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int sent [NC];
  int rcv  [NC];
  int done_cnt;
  int base;

  bp_input_assembler_if link ();

  bp_input_assembler dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .length (length),
    .busy   (busy),
    .done   (done),
    .link   (link)
  );

  always #5 clk = ~clk;

  // Beat k of channel c: byte {n, n^c} repeated, n = 0xA + base + k
  function automatic logic [255:0] beat(int c, int k);
    logic [3:0] n;
    logic [7:0] b;
    n = 4'(10 + base + k);
    b = {n, n ^ 4'(c)};
    beat = {32{b}};
  endfunction

  function automatic logic [511:0] slice(int c, int v);
    slice = {beat(c, 2*v+1), beat(c, 2*v)};
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_chk(string t, int i, logic [7:0] e_rdy, logic [7:0] e_vld,
                         logic e_busy, logic e_done);
    chk($sformatf("%s_i%0d_rdy", t, i), link.s_axi_rdy, e_rdy);
    chk($sformatf("%s_i%0d_vld", t, i), link.dn_vld, e_vld);
    chk($sformatf("%s_i%0d_busy", t, i), busy, e_busy);
    chk($sformatf("%s_i%0d_done", t, i), done, e_done);
  endtask

  task automatic new_frame(int b);
    base = b;
    done_cnt = 0;
    for (int c = 0; c < NC; c++) begin
      sent[c] = 0;
      rcv[c]  = 0;
    end
  endtask

  // One clock: drive next beats, check any valid slice in order, account handshakes
  task automatic step();
    logic [NC-1:0] acc;
    logic [NC-1:0] hs;
    for (int c = 0; c < NC; c++) link.s_axi_dat[c*256 +: 256] = beat(c, sent[c]);
    acc = link.s_axi_vld & link.s_axi_rdy;
    hs  = link.dn_vld & {NC{link.dn_rdy}};
    if (done) done_cnt++;
    for (int c = 0; c < NC; c++) begin
      if (link.dn_vld[c])
        chk($sformatf("dat_c%0d_v%0d", c, rcv[c]), link.dn_dat[c*512 +: 512], slice(c, rcv[c]));
    end
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      sent[c] += int'(acc[c]);
      rcv[c]  += int'(hs[c]);
    end
    @(negedge clk);
  endtask

  task automatic frame_end_chk(string t, int beats, int vecs);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("%s_sent_c%0d", t, c), sent[c], beats);
      chk($sformatf("%s_rcv_c%0d", t, c), rcv[c], vecs);
    end
    chk($sformatf("%s_done_cnt", t), done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    length = '0;
    link.s_axi_vld = '0;
    link.s_axi_dat = '0;
    link.dn_rdy = 1'b0;
    new_frame(0);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_rdy", link.s_axi_rdy, 0);
    chk("rst_vld", link.dn_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dat", link.dn_dat[511:0], 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: length 4, all channels streaming, engines always ready
    link.s_axi_vld = 8'hFF;
    link.dn_rdy = 1'b1;
    new_frame(0);
    length = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cyc_chk("t1", i, (i <= 7) ? 8'hFF : 8'h00,
              (i == 2 || i == 4 || i == 6 || i == 8) ? 8'hFF : 8'h00, i <= 9, i == 10);
      if (i == 2) chk("t1_ch0_AB", link.dn_dat[511:0], {{64{4'hB}}, {64{4'hA}}});
      step();
    end
    frame_end_chk("t1", 8, 4);

    // T2: engines stall for 6 cycles while the first slice is presented
    new_frame(0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      link.dn_rdy = !(i >= 2 && i <= 7);
      cyc_chk("t2", i, (i <= 3 || (i >= 9 && i <= 12)) ? 8'hFF : 8'h00,
              ((i >= 2 && i <= 9) || i == 11 || i == 13) ? 8'hFF : 8'h00, i <= 14, i == 15);
      step();
    end
    link.dn_rdy = 1'b1;
    frame_end_chk("t2", 8, 4);

    // T3: channel 3 offers a beat only every third cycle
    new_frame(0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 28; i++) begin
      link.s_axi_vld = {4'hF, (i % 3 == 0), 3'h7};
      cyc_chk("t3", i, (i <= 7) ? 8'hFF : ((i <= 21) ? 8'h08 : 8'h00),
              ((i == 2 || i == 4 || i == 6 || i == 8) ? 8'hF7 : 8'h00) |
              ((i == 4 || i == 10 || i == 16 || i == 22) ? 8'h08 : 8'h00),
              i <= 23, i == 24);
      step();
    end
    link.s_axi_vld = 8'hFF;
    frame_end_chk("t3", 8, 4);

    // T4: zero-length frame
    new_frame(0);
    length = 16'd0;
    for (int j = 0; j < 4; j++) begin
      start = (j == 0);
      cyc_chk("t4", j, 8'h00, 8'h00, 1'b0, j == 1);
      step();
    end
    start = 1'b0;
    chk("t4_done_cnt", done_cnt, 1);

    // T5: reset after 3 beats, then a clean length-1 frame with fresh data
    new_frame(0);
    length = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_rdy", link.s_axi_rdy, 0);
    chk("t5_rst_vld", link.dn_vld, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    for (int c = 0; c < NC; c++)
      chk($sformatf("t5_rst_dat_c%0d", c), link.dn_dat[c*512 +: 512], 0);
    new_frame(8);
    length = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc_chk("t5", i, (i <= 1) ? 8'hFF : 8'h00, (i == 2) ? 8'hFF : 8'h00, i <= 3, i == 4);
      step();
    end
    frame_end_chk("t5", 2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bp_input_assembler.md
Name: bp_input_assembler

Overview:
Upstream stage of the butterfly processor. It collects per-channel AXI read beats from the input DMA and assembles them into the wide real+complex vector (2*data_width*be_parallelism bits) that the butterfly engines consume. It drives one valid per input AXI channel and honours the single shared engine ready. It also tracks frame length, counting vectors per channel, and flags frame completion.

Parameters:
DATA_WIDTH_AXI, 256, width of one AXI beat per channel
INPUT_AXI_CHNL, 8, number of input AXI channels
data_width, 16, width of the real part and of the imaginary part of each sample
be_parallelism, 128, number of complex samples per vector
CHNL_W (local), 2*data_width*be_parallelism/INPUT_AXI_CHNL = 512, vector slice owned by one channel
BEATS (local), CHNL_W/DATA_WIDTH_AXI = 2, beats per slice; must be an integer >= 1

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; length is sampled on the same cycle
length  in  16  vectors per channel in the frame
s_axi_dat  in  DATA_WIDTH_AXI*INPUT_AXI_CHNL  beat data; channel c occupies bits [c*DATA_WIDTH_AXI +: DATA_WIDTH_AXI]
s_axi_vld  in  INPUT_AXI_CHNL  per-channel beat valid
s_axi_rdy  out  INPUT_AXI_CHNL  per-channel beat ready
dn_dat  out  2*data_width*be_parallelism  assembled vector; channel c drives bits [c*CHNL_W +: CHNL_W]
dn_vld  out  INPUT_AXI_CHNL  per-channel slice valid
dn_rdy  in  1  shared engine ready
busy  out  1  high while the state is RUN
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (synchronous, rst=1): state=IDLE. s_axi_rdy=0, dn_vld=0, dn_dat=0, busy=0, done=0. All counters and full flags cleared. Reset mid-frame discards any partial data.
- FSM IDLE -> RUN: start=1 and length!=0. Latch length into len_q.
- FSM IDLE, start=1, length==0: stay IDLE; done=1 on the next cycle.
- FSM RUN -> DONE: every channel has vec_cnt==len_q and dn_vld==0.
- FSM DONE -> IDLE: unconditional after 1 cycle; done=1 during DONE.
- start while in RUN or DONE is ignored.
- Per-channel state:
  - beat_idx, 0..BEATS-1
  - beats_acc, 0..len_q*BEATS, 32-bit
  - asm register, CHNL_W bits
  - asm_full flag
  - out register with out_vld (= dn_vld[c])
  - vec_cnt, counts dn handshakes
- s_axi_rdy[c] = (state==RUN) && !asm_full[c] && (beats_acc[c] < len_q*BEATS). It is combinational from registers only and never depends on dn_rdy.
- Beat accept: s_axi_vld[c] && s_axi_rdy[c].
  - The beat is written to asm[beat_idx*DATA_WIDTH_AXI +: DATA_WIDTH_AXI]; the first beat goes in the LSBs.
  - beat_idx wraps from BEATS-1 to 0.
  - beats_acc increments by 1.
- Last beat of a slice (beat_idx==BEATS-1) accepted:
  - If !out_vld || dn_rdy: the slice (with this beat merged in) loads into out, and out_vld=1 next cycle.
  - Otherwise asm_full=1.
- Pending slice: if asm_full && (!out_vld || dn_rdy), asm moves to out, asm_full clears, and out_vld stays or goes to 1.
- Output handshake: on dn_vld[c] && dn_rdy, vec_cnt increments. out_vld clears unless a reload happens on the same cycle.
- dn_dat holds stable while dn_vld=1 and dn_rdy=0.
- Latency: last beat accepted at cycle N gives dn_vld=1 at N+1.
- Throughput: with dn_rdy=1 and vld held high, one beat per cycle per channel and one slice per BEATS cycles, with no bubbles.
- Channels are independent. No cross-channel alignment is enforced; the engines synchronise through the shared ready.
- Frame end: when beats_acc reaches len_q*BEATS, s_axi_rdy drops the next cycle. Surplus upstream beats are never accepted.

Test Plan:
- Reset, then start with length=4, all channels streaming with vld=1 and dn_rdy=1 -> each channel accepts 8 beats. dn_vld pulses at cycles 2,4,6,8 after the first accept. s_axi_rdy=0 after beat 8. done=1 exactly once. busy falls with done.
- Channel 0 beats 0xA..A then 0xB..B -> dn_dat[511:0] = {B..B, A..A}. Other channels carry distinct patterns, each appearing in its own slice.
- dn_rdy=0 for 6 cycles mid-frame -> out holds its first slice and asm fills and sets asm_full. s_axi_rdy=0 until dn_rdy returns. No data is lost or duplicated, and the sequence checks in order.
- Random s_axi_vld gaps on channel 3 only -> channel 3 dn_vld lags the other channels. The frame completes only after channel 3 delivers 4 slices. done fires once.
- start with length=0 -> no s_axi_rdy assertion; done=1 on the next cycle; busy stays 0.
- rst=1 after 3 beats of a 4-vector frame -> all outputs 0 next cycle. A new start with length=1 then completes cleanly with no stale data in dn_dat.
